// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and constants for the iterative divider
package div_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    function automatic logic is_signed_op(input logic [2:0] f);
        return (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f);
        return (f == F3_REM) || (f == F3_REMU);
    endfunction

endpackage

// File: rtl/div_step_32bit.sv
// rtl/div_step_32bit.sv - one radix-2 restoring division step (combinational)
module div_step_32bit #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   i_rem,
    input  logic            i_q_msb,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic            o_q_bit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {i_rem[XLEN-1:0], i_q_msb};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // The incoming top bit is always zero after a restoring step; folding it in keeps the compare total.
    assign o_q_bit = i_rem[XLEN] | (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_q_bit ? w_diff : w_shift;

endmodule

// File: rtl/div_unit_32bit.sv
// rtl/div_unit_32bit.sv - iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock
module div_unit_32bit
    import div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN:0]    r_rem;
    logic [XLEN-1:0]  r_q;
    logic [XLEN-1:0]  r_divisor;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_signed;
    logic             w_is_rem;
    logic [XLEN-1:0]  w_abs1;
    logic [XLEN-1:0]  w_abs2;
    logic             w_div_zero;
    logic             w_overflow;
    logic [XLEN:0]    w_rem_next;
    logic             w_q_bit;
    logic [XLEN-1:0]  w_q_fin;
    logic [XLEN-1:0]  w_r_fin;
    logic [XLEN-1:0]  w_result_fin;

    assign w_signed   = is_signed_op(FUNCT3);
    assign w_is_rem   = is_rem_op(FUNCT3);
    assign w_abs1     = (w_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
    assign w_abs2     = (w_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;
    assign w_div_zero = (DATA2 == '0);
    assign w_overflow = w_signed && (DATA1 == INT_MIN) && (DATA2 == ALL_ONES);

    div_step_32bit #(.XLEN(XLEN)) u_step (
        .i_rem     (r_rem),
        .i_q_msb   (r_q[XLEN-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    // Final step's outputs are used directly so the result lands on the 32nd edge.
    assign w_q_fin      = {r_q[XLEN-2:0], w_q_bit};
    assign w_r_fin      = w_rem_next[XLEN-1:0];
    assign w_result_fin = r_is_rem ? (r_neg_r ? -w_r_fin : w_r_fin)
                                   : (r_neg_q ? -w_q_fin : w_q_fin);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (FLUSH) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_fin;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_result <= w_result_fin;
                        r_state  <= S_FIN;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    if (START) begin
                        r_is_rem  <= w_is_rem;
                        r_neg_q   <= w_signed & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
                        r_neg_r   <= w_signed & DATA1[XLEN-1];
                        r_divisor <= w_abs2;
                        if (w_div_zero) begin
                            r_result <= w_is_rem ? DATA1 : ALL_ONES;
                            r_state  <= S_FIN;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else if (w_overflow) begin
                            r_result <= w_is_rem ? '0 : INT_MIN;
                            r_state  <= S_FIN;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= w_abs1;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign RESULT = r_result;
    assign BUSY   = r_busy;
    assign DONE   = r_done;

endmodule

// File: tb/tb_div_unit_32bit.sv
// tb/tb_div_unit_32bit.sv - self-checking bench for div_unit_32bit
module tb_div_unit_32bit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        FLUSH;
    logic [31:0] RESULT;
    logic        BUSY;
    logic        DONE;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    div_unit_32bit dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FUNCT3 (FUNCT3),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .RESULT (RESULT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic; SV / and % truncate toward zero.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit     sgn = (f == 3'b100) || (f == 3'b110);
        bit     rem = (f == 3'b110) || (f == 3'b111);
        longint sa, sb, q, r;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return rem ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sgn = (f == 3'b100) || (f == 3'b110);
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
        return 32;
    endfunction

    // k counts clock edges after the START edge at which DONE is first seen.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int k, output int busy_n, output bit res_moved, output logic [31:0] res);
        logic [31:0] held;
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f; DATA1 = a; DATA2 = b;
        held = RESULT;
        @(posedge CLK); #1;
        START = 1'b0;
        k = 0; busy_n = 0; res_moved = 1'b0;
        while (!DONE && k < 40) begin
            if (BUSY) busy_n++;
            if (RESULT !== held) res_moved = 1'b1;
            @(posedge CLK); #1;
            k++;
        end
        res = RESULT;
    endtask

    task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int lat, input bit tail);
        int          k, busy_n;
        bit          moved;
        logic [31:0] res;
        run_op(f, a, b, k, busy_n, moved, res);
        chk($sformatf("%s result", name), res, exp);
        chk($sformatf("%s latency", name), 32'(k), 32'(lat));
        chk($sformatf("%s busy_cycles", name), 32'(busy_n), 32'(lat));
        chk($sformatf("%s result_held", name), 32'(moved), 32'd0);
        if (tail) begin
            @(posedge CLK); #1;
            chk($sformatf("%s done_pulse", name), {31'd0, DONE}, 32'd0);
            chk($sformatf("%s idle_busy", name), {31'd0, BUSY}, 32'd0);
        end
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            if (DONE) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        logic [31:0] prev, a, b;
        logic [2:0]  f;
        int          k;

        vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14,          32};
        vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2,           32};
        vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   32};
        vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   32};
        vecs[4]  = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,           32};
        vecs[5]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,   0};
        vecs[6]  = '{3'b111, 32'd5,          32'd0,          32'd5,           0};
        vecs[7]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   0};
        vecs[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           0};
        vecs[9]  = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,   32};
        vecs[10] = '{3'b111, 32'hFFFF_FFFF,  32'h10,         32'hF,           32};
        vecs[11] = '{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,          32};
        vecs[12] = '{3'b110, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,   32};
        vecs[13] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           32};
        vecs[14] = '{3'b100, 32'h8000_0000,  32'd1,          32'h8000_0000,   32};

        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        FUNCT3 = 3'b101; DATA1 = 32'd0; DATA2 = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset RESULT", RESULT, 32'd0);
        chk("reset BUSY", {31'd0, BUSY}, 32'd0);
        chk("reset DONE", {31'd0, DONE}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 15; i++)
            check_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);

        // Flush at CALC step 10, with START raised alongside to confirm FLUSH wins.
        prev = RESULT;
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd1000; DATA2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        chk("flush BUSY", {31'd0, BUSY}, 32'd0);
        chk("flush DONE", {31'd0, DONE}, 32'd0);
        chk("flush RESULT", RESULT, prev);
        @(negedge CLK);
        FLUSH = 1'b0; START = 1'b0;
        expect_no_done("flush no_done", 40);
        check_op("after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 32, 1'b1);

        // START re-pulsed during CALC with a divide-by-zero request must be ignored.
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd100; DATA2 = 32'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        k = 0;
        repeat (4) begin @(posedge CLK); #1; k++; end
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b111; DATA1 = 32'd5; DATA2 = 32'd0;
        @(posedge CLK); #1;
        k++;
        START = 1'b0;
        chk("repulse BUSY", {31'd0, BUSY}, 32'd1);
        while (!DONE && k < 40) begin @(posedge CLK); #1; k++; end
        chk("repulse latency", 32'(k), 32'd32);
        chk("repulse result", RESULT, 32'd14);
        @(posedge CLK); #1;

        // Reset in the middle of CALC.
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd5000; DATA2 = 32'd9;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("midreset RESULT", RESULT, 32'd0);
        chk("midreset BUSY", {31'd0, BUSY}, 32'd0);
        chk("midreset DONE", {31'd0, DONE}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        expect_no_done("midreset no_done", 40);

        // Back-to-back: the second START lands while the first is in FIN.
        check_op("b2b_first", 3'b101, 32'd100, 32'd7, 32'd14, 32, 1'b0);
        check_op("b2b_second", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 1'b1);
        check_op("b2b_spec_first", 3'b111, 32'd77, 32'd0, 32'd77, 0, 1'b0);
        check_op("b2b_spec_second", 3'b111, 32'd77, 32'd10, 32'd7, 32, 1'b1);

        for (int i = 0; i < 50; i++) begin
            f = 3'b100 | 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: b = $urandom;
            endcase
            check_op($sformatf("rand%0d f=%b a=%08h b=%08h", i, f, a, b), f, a, b,
                     ref_model(f, a, b), ref_lat(f, a, b), i[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
